// File: rtl/fcmp_unit.sv
// rtl/fcmp_unit.sv - two-stage binary32 compare/select unit (FLT/FLE/FEQ/FMIN/FMAX)
// Optional NaN handling and out_nv port enabled by defining FCMP_NAN_EN.
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef FCMP_NAN_EN
    ,
    output logic             out_nv
`endif
);

    localparam logic [2:0] OP_FLT  = 3'b000;
    localparam logic [2:0] OP_FLE  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [31:0]      s1_x1;
    logic [31:0]      s1_x2;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_sgn1;
    logic             s1_sgn2;
    logic             s1_mag_lt;
    logic             s1_mag_eq;
    logic             s1_both_zero;

    logic s2_load;
    logic in_fire;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

`ifdef FCMP_NAN_EN
    logic s1_nan1;
    logic s1_nan2;
    logic s1_snan;
    logic in_nan1;
    logic in_nan2;

    assign in_nan1 = (&in_x1[30:23]) && (|in_x1[22:0]);
    assign in_nan2 = (&in_x2[30:23]) && (|in_x2[22:0]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Payload registers are intentionally left unreset; s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_op        <= in_op;
            s1_x1        <= in_x1;
            s1_x2        <= in_x2;
            s1_tag       <= in_tag;
            s1_sgn1      <= in_x1[31];
            s1_sgn2      <= in_x2[31];
            s1_mag_lt    <= in_x1[30:0] < in_x2[30:0];
            s1_mag_eq    <= in_x1[30:0] == in_x2[30:0];
            s1_both_zero <= (in_x1[30:0] == 31'd0) && (in_x2[30:0] == 31'd0);
`ifdef FCMP_NAN_EN
            s1_nan1      <= in_nan1;
            s1_nan2      <= in_nan2;
            s1_snan      <= (in_nan1 && !in_x1[22]) || (in_nan2 && !in_x2[22]);
`endif
        end
    end

    logic        lt;
    logic        eq;
    logic        unord;
    logic [31:0] res;
    logic        res_ill;

    // Both-negative ordering inverts the magnitude compare; +0/-0 fold to equal.
    assign eq = s1_both_zero || ((s1_sgn1 == s1_sgn2) && s1_mag_eq);
    assign lt = (s1_sgn1 != s1_sgn2) ? (s1_sgn1 && !s1_both_zero)
              : (s1_sgn1 ? !(s1_mag_lt || s1_mag_eq) : s1_mag_lt);

`ifdef FCMP_NAN_EN
    assign unord = s1_nan1 || s1_nan2;
`else
    assign unord = 1'b0;
`endif

    always_comb begin
        res     = 32'h0;
        res_ill = 1'b0;
        case (s1_op)
            OP_FLT:  res = {31'b0, lt && !unord};
            OP_FLE:  res = {31'b0, (lt || eq) && !unord};
            OP_FEQ:  res = {31'b0, eq && !unord};
            OP_FMIN: res = (lt || eq) ? s1_x1 : s1_x2;
            OP_FMAX: res = lt ? s1_x2 : s1_x1;
            default: res_ill = 1'b1;
        endcase
`ifdef FCMP_NAN_EN
        if (s1_op == OP_FMIN || s1_op == OP_FMAX) begin
            if (s1_nan1 && s1_nan2) begin
                res = 32'h7FC0_0000;
            end else if (s1_nan1) begin
                res = s1_x2;
            end else if (s1_nan2) begin
                res = s1_x1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= 32'h0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
`ifdef FCMP_NAN_EN
            out_nv      <= 1'b0;
`endif
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= res;
                out_tag     <= s1_tag;
                out_illegal <= res_ill;
`ifdef FCMP_NAN_EN
                out_nv      <= s1_snan;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fcmp_unit.sv
// tb/tb_fcmp_unit.sv - self-checking bench for fcmp_unit with ordering-key reference model
module tb_fcmp_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
`ifdef FCMP_NAN_EN
    logic             out_nv;
`endif

    fcmp_unit #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x1      (in_x1),
        .in_x2      (in_x2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
`ifdef FCMP_NAN_EN
        ,
        .out_nv     (out_nv)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;

    logic             accepted;
    logic             samp_rdy;
    logic             rand_ready = 1'b0;
    logic             ovr_en     = 1'b0;
    logic [31:0]      ovr_d;
    logic             ovr_ill;
    logic             ovr_nv;

    logic [31:0]      q_data[$];
    logic [TAG_W-1:0] q_tag[$];
    logic             q_ill[$];
    logic             q_nv[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    // Ordering key: signed integer of the sign-magnitude value, so +0 and -0 coincide.
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic ill, output logic nv);
        logic lt, eq, na, nb;
        lt  = key(a) < key(b);
        eq  = key(a) == key(b);
        na  = 1'b0;
        nb  = 1'b0;
        nv  = 1'b0;
        ill = 1'b0;
        d   = 32'h0;
`ifdef FCMP_NAN_EN
        na = is_nan(a);
        nb = is_nan(b);
        nv = (na && !a[22]) || (nb && !b[22]);
`endif
        case (op)
            3'd0: d = {31'b0, lt && !(na || nb)};
            3'd1: d = {31'b0, (lt || eq) && !(na || nb)};
            3'd2: d = {31'b0, eq && !(na || nb)};
            3'd3: d = (na && nb) ? 32'h7FC0_0000 : na ? b : nb ? a : (key(b) < key(a)) ? b : a;
            3'd4: d = (na && nb) ? 32'h7FC0_0000 : na ? b : nb ? a : (key(a) < key(b)) ? b : a;
            default: ill = 1'b1;
        endcase
    endtask

    task automatic step();
        logic [31:0] d;
        logic        il;
        logic        nv;
        @(negedge clk);
        samp_rdy = in_ready;
        accepted = 1'b0;
        if (!rst) begin
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                if (ovr_en) begin
                    d  = ovr_d;
                    il = ovr_ill;
                    nv = ovr_nv;
                end else begin
                    model(in_op, in_x1, in_x2, d, il, nv);
                end
                q_data.push_back(d);
                q_tag.push_back(in_tag);
                q_ill.push_back(il);
                q_nv.push_back(nv);
            end
            if (out_valid && out_ready) begin
                check("unexpected_out", 32'(q_data.size() != 0), 32'd1);
                if (q_data.size() != 0) begin
                    check("out_data", out_data, q_data.pop_front());
                    check("out_tag", 32'(out_tag), 32'(q_tag.pop_front()));
                    check("out_illegal", 32'(out_illegal), 32'(q_ill.pop_front()));
`ifdef FCMP_NAN_EN
                    check("out_nv", 32'(out_nv), 32'(q_nv.pop_front()));
`else
                    void'(q_nv.pop_front());
`endif
                    n_out++;
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            q_data.delete();
            q_tag.delete();
            q_ill.delete();
            q_nv.delete();
        end
        #1;
        cyc++;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = t;
        for (int k = 0; k < 64; k++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        ovr_en   = 1'b0;
    endtask

    task automatic send_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [31:0] d,
                            input logic il, input logic nv);
        ovr_en  = 1'b1;
        ovr_d   = d;
        ovr_ill = il;
        ovr_nv  = nv;
        send(op, a, b, t);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q_data.size() != 0; k++) step();
        check("drain_empty", 32'(q_data.size()), 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return {r[31], 31'h3F80_0000};
            3: return {r[31], 31'h7F80_0000};
            4: return {r[31], 8'hFF, r[22:0] | 23'd1};
            5: return {r[31], 23'd0, r[7:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        int c0;
        int n0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_x1     = 32'h0;
        in_x2     = 32'h0;
        in_tag    = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send_exp(3'd0, 32'hBF80_0000, 32'h3F80_0000, 5'd3, 32'd1, 1'b0, 1'b0);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_data", out_data, 32'd1);
        check("lat_cycle2_tag", 32'(out_tag), 32'd3);
        send_exp(3'd0, 32'h3F80_0000, 32'hBF80_0000, 5'd4, 32'd0, 1'b0, 1'b0);
        send_exp(3'd2, 32'h8000_0000, 32'h0000_0000, 5'd5, 32'd1, 1'b0, 1'b0);
        send_exp(3'd0, 32'h8000_0000, 32'h0000_0000, 5'd6, 32'd0, 1'b0, 1'b0);
        send_exp(3'd0, 32'hC000_0000, 32'hBF80_0000, 5'd7, 32'd1, 1'b0, 1'b0);
        send_exp(3'd3, 32'h4040_0000, 32'h4000_0000, 5'd8, 32'h4000_0000, 1'b0, 1'b0);
        send_exp(3'd4, 32'h4040_0000, 32'h4000_0000, 5'd9, 32'h4040_0000, 1'b0, 1'b0);
        send_exp(3'd4, 32'h0000_0000, 32'h8000_0000, 5'd10, 32'h0000_0000, 1'b0, 1'b0);
        send_exp(3'd7, 32'h4040_0000, 32'h4000_0000, 5'd11, 32'h0000_0000, 1'b1, 1'b0);
`ifdef FCMP_NAN_EN
        send_exp(3'd1, 32'h7FC0_0000, 32'h3F80_0000, 5'd12, 32'd0, 1'b0, 1'b0);
        send_exp(3'd3, 32'h7FC0_0000, 32'h3F80_0000, 5'd13, 32'h3F80_0000, 1'b0, 1'b0);
        send_exp(3'd2, 32'h7F80_0001, 32'h7F80_0001, 5'd14, 32'd0, 1'b0, 1'b1);
`endif
        drain();

        // Backpressure: pipe fills after two accepts and then holds.
        out_ready = 1'b0;
        send(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd16);
        send(3'd4, 32'hC040_0000, 32'h4000_0000, 5'd17);
        in_valid = 1'b1;
        in_op    = 3'd3;
        in_x1    = 32'h4110_0000;
        in_x2    = 32'hC110_0000;
        in_tag   = 5'd18;
        step();
        check("bp_in_ready_low", 32'(samp_rdy), 32'd0);
        held = out_data;
        step();
        step();
        check("bp_in_ready_held", 32'(samp_rdy), 32'd0);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        check("bp_out_data_stable", out_data, held);
        out_ready = 1'b1;
        c0 = cyc;
        n0 = n_out;
        send(3'd3, 32'h4110_0000, 32'hC110_0000, 5'd18);
        send(3'd1, 32'h8000_0000, 32'h0000_0000, 5'd19);
        send(3'd2, 32'h4000_0000, 32'h4000_0000, 5'd20);
        send(3'd5, 32'h1234_5678, 32'h8765_4321, 5'd21);
        for (int k = 0; k < 50 && n_out < n0 + 6; k++) step();
        check("bp_results", 32'(n_out - n0), 32'd6);
        check("bp_one_per_cycle", 32'(cyc - c0), 32'd6);

        // Reset with two operations in flight discards them.
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0001, 32'h0000_0002, 5'd22);
        send(3'd4, 32'h0000_0003, 32'h0000_0004, 5'd23);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 5; k++) step();
        check("midrst_no_stale", 32'(n_out - n0), 32'd0);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            a = rnd_val();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                default: b = rnd_val();
            endcase
            send(3'($urandom_range(0, 7)), a, b, 5'(i));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
